// File: rtl/zigzag_block_scheduler.sv
// zigzag_block_scheduler
// Feeds run/level tokens from the entropy decoder into zigzag_decoder one
// 64-coefficient block at a time. Tracks the in-block coefficient position,
// expands EOB into a zero fill token that completes the block, and holds off
// any block-completing token until the previous block has drained (8 columns
// plus a guard window). Counts drained blocks and keeps sticky error flags.
//
// Drain FSM states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no block draining; a completing token may be accepted
//   ST_WAIT  | block issued, counting decoder columns, timeout armed
//   ST_GUARD | 8th column seen (or timeout); waiting for mask clear
module zigzag_block_scheduler #(
    parameter int GUARD_CYCLES  = 2,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int BLK_CNT_W     = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [11:0]          tok_value_in,
    input  logic [5:0]           tok_run_in,
    input  logic                 tok_eob_in,
    input  logic                 tok_valid_in,
    output logic                 tok_ready_out,
    output logic [11:0]          zz_value_out,
    output logic [5:0]           zz_run_out,
    output logic                 zz_valid_out,
    input  logic                 col_valid_in,
    output logic [2:0]           col_index_out,
    output logic                 block_done_out,
    output logic [BLK_CNT_W-1:0] block_count_out,
    output logic                 overrun_err_out,
    output logic                 timeout_err_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    // Timers are down-counters: loaded on state entry, event fires at zero.
    localparam int TMO_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int GRD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(DRAIN_TIMEOUT - 1);
    localparam logic [GRD_W-1:0] GRD_LOAD = GRD_W'(GUARD_CYCLES - 1);

    logic [1:0]       state_q;
    logic [5:0]       pos_q;
    logic [2:0]       col_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [GRD_W-1:0] grd_cnt_q;

    logic [6:0]       fill;
    logic [5:0]       issue_run;
    logic [11:0]      issue_value;
    logic             completing;
    logic             overrun;
    logic             accept;

    // Token fill math, EOB expansion and the stall rule for completing tokens.
    always_comb begin
        issue_run   = tok_run_in;
        issue_value = tok_value_in;
        fill        = {1'b0, pos_q} + {1'b0, tok_run_in} + 7'd1;
        if (tok_eob_in) begin
            issue_run   = 6'd63 - pos_q;
            issue_value = 12'd0;
            fill        = 7'd64;
        end
        completing    = fill[6];
        overrun       = !tok_eob_in && (fill > 7'd64);
        tok_ready_out = !rst_in && !(completing && (state_q != ST_IDLE));
        accept        = tok_valid_in && tok_ready_out;
    end

    // Issue register toward zigzag_decoder, coefficient position and overrun flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pos_q           <= 6'd0;
            zz_value_out    <= 12'd0;
            zz_run_out      <= 6'd0;
            zz_valid_out    <= 1'b0;
            overrun_err_out <= 1'b0;
        end else begin
            zz_valid_out <= accept;
            if (accept) begin
                zz_value_out <= issue_value;
                zz_run_out   <= issue_run;
                // An overrunning token still completes the block: the decoder
                // swaps buffers on it, so position restarts at 0.
                pos_q        <= completing ? 6'd0 : fill[5:0];
                if (overrun) begin
                    overrun_err_out <= 1'b1;
                end
            end
        end
    end

    // Drain tracking: column counting, block completion, timeout and guard window.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q         <= ST_IDLE;
            col_cnt_q       <= 3'd0;
            tmo_cnt_q       <= '0;
            grd_cnt_q       <= '0;
            col_index_out   <= 3'd0;
            block_done_out  <= 1'b0;
            block_count_out <= '0;
            timeout_err_out <= 1'b0;
        end else begin
            block_done_out <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept && completing) begin
                        state_q   <= ST_WAIT;
                        col_cnt_q <= 3'd0;
                        tmo_cnt_q <= TMO_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (col_valid_in) begin
                        col_index_out <= col_cnt_q;
                        col_cnt_q     <= col_cnt_q + 3'd1;
                    end
                    if (col_valid_in && (col_cnt_q == 3'd7)) begin
                        block_done_out  <= 1'b1;
                        block_count_out <= block_count_out + BLK_CNT_W'(1);
                        state_q         <= ST_GUARD;
                        grd_cnt_q       <= GRD_LOAD;
                    end else if (tmo_cnt_q == '0) begin
                        // Force release so a stuck decoder cannot wedge the stream.
                        timeout_err_out <= 1'b1;
                        state_q         <= ST_GUARD;
                        grd_cnt_q       <= GRD_LOAD;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
                    end
                end
                ST_GUARD: begin
                    if (grd_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        grd_cnt_q <= grd_cnt_q - GRD_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zigzag_block_scheduler.sv
// Directed bench for zigzag_block_scheduler: hand-computed token/column vectors.
module tb_zigzag_block_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [11:0] tok_value_in;
    logic [5:0]  tok_run_in;
    logic        tok_eob_in;
    logic        tok_valid_in;
    logic        tok_ready_out;
    logic [11:0] zz_value_out;
    logic [5:0]  zz_run_out;
    logic        zz_valid_out;
    logic        col_valid_in;
    logic [2:0]  col_index_out;
    logic        block_done_out;
    logic [15:0] block_count_out;
    logic        overrun_err_out;
    logic        timeout_err_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    zigzag_block_scheduler #(
        .GUARD_CYCLES (2),
        .DRAIN_TIMEOUT(64),
        .BLK_CNT_W    (16)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .tok_value_in   (tok_value_in),
        .tok_run_in     (tok_run_in),
        .tok_eob_in     (tok_eob_in),
        .tok_valid_in   (tok_valid_in),
        .tok_ready_out  (tok_ready_out),
        .zz_value_out   (zz_value_out),
        .zz_run_out     (zz_run_out),
        .zz_valid_out   (zz_valid_out),
        .col_valid_in   (col_valid_in),
        .col_index_out  (col_index_out),
        .block_done_out (block_done_out),
        .block_count_out(block_count_out),
        .overrun_err_out(overrun_err_out),
        .timeout_err_out(timeout_err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Present one token that must be accepted immediately; check the issue one cycle later.
    task automatic send(input string tag, input logic [11:0] v, input logic [5:0] r,
                        input logic e, input logic [11:0] ev, input logic [5:0] er);
        tok_value_in = v;
        tok_run_in   = r;
        tok_eob_in   = e;
        tok_valid_in = 1'b1;
        #1;
        chk({tag, " ready"}, 32'(tok_ready_out), 32'd1);
        step();
        tok_valid_in = 1'b0;
        chk({tag, " zz_valid"}, 32'(zz_valid_out), 32'd1);
        chk({tag, " zz_value"}, 32'(zz_value_out), 32'(ev));
        chk({tag, " zz_run"},   32'(zz_run_out),   32'(er));
    endtask

    // Eight decoder columns; checks index per column and the done pulse on the last.
    task automatic drain8(input string tag);
        for (int i = 0; i < 8; i++) begin
            col_valid_in = 1'b1;
            step();
            chk({tag, " col_index"}, 32'(col_index_out), 32'(i));
            chk({tag, " block_done"}, 32'(block_done_out), (i == 7) ? 32'd1 : 32'd0);
        end
        col_valid_in = 1'b0;
    endtask

    initial begin
        rst_in       = 1'b1;
        tok_value_in = 12'd0;
        tok_run_in   = 6'd0;
        tok_eob_in   = 1'b0;
        tok_valid_in = 1'b0;
        col_valid_in = 1'b0;
        step();
        chk("rst ready",   32'(tok_ready_out),   32'd0);
        chk("rst zz",      32'({zz_valid_out, zz_value_out, zz_run_out}), 32'd0);
        chk("rst count",   32'(block_count_out), 32'd0);
        chk("rst errs",    32'({overrun_err_out, timeout_err_out}), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        step();

        // 1: basic block, pos 0 -> 1 -> 4, EOB fills 59 zeros + final zero
        send("t1 a", 12'd5,   6'd0, 1'b0, 12'd5,   6'd0);
        send("t1 b", 12'hFFD, 6'd2, 1'b0, 12'hFFD, 6'd2);
        send("t1 eob", 12'h123, 6'd9, 1'b1, 12'd0, 6'd59);
        drain8("t1");
        chk("t1 count", 32'(block_count_out), 32'd1);
        step();
        chk("t1 done pulse end", 32'(block_done_out), 32'd0);
        step();

        // 2: EOB at pos 0 is a full zero block
        send("t2 eob", 12'd0, 6'd0, 1'b1, 12'd0, 6'd63);

        // 3: non-completing write overlaps drain; completing EOB stalls until guard ends
        send("t3 a", 12'd9, 6'd10, 1'b0, 12'd9, 6'd10);
        tok_eob_in   = 1'b1;
        tok_valid_in = 1'b1;
        #1;
        chk("t3 stall ready", 32'(tok_ready_out), 32'd0);
        drain8("t3");
        chk("t3 count", 32'(block_count_out), 32'd2);
        chk("t3 guard0 ready", 32'(tok_ready_out), 32'd0);
        step();
        chk("t3 guard1 ready", 32'(tok_ready_out), 32'd0);
        chk("t3 stall zz_valid", 32'(zz_valid_out), 32'd0);
        step();
        chk("t3 idle ready", 32'(tok_ready_out), 32'd1);
        step();
        tok_valid_in = 1'b0;
        chk("t3 eob zz_valid", 32'(zz_valid_out), 32'd1);
        chk("t3 eob zz_run",   32'(zz_run_out),   32'd52);
        chk("t3 eob zz_value", 32'(zz_value_out), 32'd0);
        step();
        chk("t3 no dup", 32'(zz_valid_out), 32'd0);

        // 5: no columns after block 3 issue -> timeout after 64 WAIT cycles
        repeat (62) step();
        chk("t5 pre-timeout", 32'(timeout_err_out), 32'd0);
        step();
        chk("t5 timeout", 32'(timeout_err_out), 32'd1);
        tok_eob_in   = 1'b1;
        tok_valid_in = 1'b1;
        #1;
        chk("t5 guard ready", 32'(tok_ready_out), 32'd0);
        step();
        chk("t5 guard1 ready", 32'(tok_ready_out), 32'd0);
        step();
        chk("t5 idle ready", 32'(tok_ready_out), 32'd1);
        tok_valid_in = 1'b0;
        chk("t5 count", 32'(block_count_out), 32'd2);

        // 4: overrun from pos 60 with run 5, block still completes, pos back to 0
        chk("t4 pre overrun", 32'(overrun_err_out), 32'd0);
        send("t4 a", 12'd1, 6'd59, 1'b0, 12'd1, 6'd59);
        send("t4 ovr", 12'd100, 6'd5, 1'b0, 12'd100, 6'd5);
        chk("t4 overrun", 32'(overrun_err_out), 32'd1);
        drain8("t4");
        chk("t4 count", 32'(block_count_out), 32'd3);
        step();
        step();
        send("t4 eob", 12'd0, 6'd0, 1'b1, 12'd0, 6'd63);
        chk("t4 timeout sticky", 32'(timeout_err_out), 32'd1);
        chk("t4 overrun sticky", 32'(overrun_err_out), 32'd1);

        // 6: reset mid-block with pos=17 and FSM in WAIT
        send("t6 a", 12'd4, 6'd16, 1'b0, 12'd4, 6'd16);
        for (int i = 0; i < 3; i++) begin
            col_valid_in = 1'b1;
            step();
        end
        col_valid_in = 1'b0;
        chk("t6 col_index pre", 32'(col_index_out), 32'd2);
        #2;
        rst_in = 1'b1;
        #1;
        chk("t6 rst ready",  32'(tok_ready_out), 32'd0);
        chk("t6 rst zz",     32'({zz_valid_out, zz_value_out, zz_run_out}), 32'd0);
        chk("t6 rst col",    32'({col_index_out, block_done_out}), 32'd0);
        chk("t6 rst count",  32'(block_count_out), 32'd0);
        chk("t6 rst errs",   32'({overrun_err_out, timeout_err_out}), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        step();
        send("t6 eob", 12'd0, 6'd0, 1'b1, 12'd0, 6'd63);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
